// File: rtl/eflags_cond_unit.sv
// Architectural EFLAGS register with masked ALU writeback, x86 tttn condition
// evaluation, and a pending-writer counter that stalls condition reads on RAW hazards.
module eflags_cond_unit #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fw_issue,
    output logic        fw_issue_ready,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [31:0] wb_flags,
    input  logic [31:0] wb_mask,
    input  logic        cc_req_valid,
    input  logic [3:0]  cc_code,
    output logic        cc_req_ready,
    output logic        cc_resp_valid,
    output logic        cc_taken,
    output logic [31:0] eflags_out
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] PEND_MAX  = CW'(MAX_PENDING);
    localparam logic [CW-1:0] PEND_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] PEND_ONE  = CW'(1);

    // Writable: OF(11) DF(10) SF(7) ZF(6) AF(4) PF(2) CF(0); bit 1 is hardwired high.
    localparam logic [31:0] WR_BITS  = 32'h0000_0CD5;
    localparam logic [31:0] FIX_ONES = 32'h0000_0002;
    localparam logic [31:0] RST_VAL  = 32'h0000_0002;

    localparam int OF_B = 11;
    localparam int SF_B = 7;
    localparam int ZF_B = 6;
    localparam int PF_B = 2;
    localparam int CF_B = 0;

    function automatic logic cond_eval(input logic [3:0] code, input logic [31:0] f);
        logic base;
        case (code[3:1])
            3'd0:    base = f[OF_B];
            3'd1:    base = f[CF_B];
            3'd2:    base = f[ZF_B];
            3'd3:    base = f[CF_B] | f[ZF_B];
            3'd4:    base = f[SF_B];
            3'd5:    base = f[PF_B];
            3'd6:    base = f[SF_B] ^ f[OF_B];
            3'd7:    base = f[ZF_B] | (f[SF_B] ^ f[OF_B]);
            default: base = 1'b0;
        endcase
        // Odd codes are the negated form of the preceding even code.
        return base ^ code[0];
    endfunction

    logic [31:0]   eflags_q;
    logic [31:0]   eflags_d;
    logic [CW-1:0] pending_q;
    logic [CW-1:0] pending_d;
    logic          resp_valid_q;
    logic          resp_valid_d;
    logic          taken_q;
    logic          taken_d;

    logic          pend_zero_s;
    logic          issue_ok_s;
    logic          retire_s;
    logic          req_ready_s;
    logic          accept_s;

    // Readiness and handshake terms.
    always_comb begin
        pend_zero_s    = (pending_q == PEND_ZERO);
        fw_issue_ready = (pending_q != PEND_MAX) | wb_valid | flush;
        issue_ok_s     = fw_issue & fw_issue_ready & ~flush;
        retire_s       = wb_valid & ~pend_zero_s;
        // pending==1 with a same-cycle writeback reads the bypassed merged flags.
        req_ready_s    = ~flush & (pend_zero_s | ((pending_q == PEND_ONE) & wb_valid));
        cc_req_ready   = req_ready_s;
        accept_s       = cc_req_valid & req_ready_s;
    end

    // Merge the writeback into the committed flags, forcing the constant bits.
    always_comb begin
        eflags_d = eflags_q;
        if (wb_valid) begin
            eflags_d = (((eflags_q & ~wb_mask) | (wb_flags & wb_mask)) & WR_BITS) | FIX_ONES;
        end else begin
            eflags_d = eflags_q;
        end
    end

    // Pending flag-writer count; flush clears it and drops same-cycle issues.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = PEND_ZERO;
        end else if (issue_ok_s && !retire_s) begin
            pending_d = pending_q + PEND_ONE;
        end else if (retire_s && !issue_ok_s) begin
            pending_d = pending_q - PEND_ONE;
        end else begin
            pending_d = pending_q;
        end
    end

    // Condition response; cc_taken holds between responses.
    always_comb begin
        resp_valid_d = accept_s;
        taken_d      = taken_q;
        if (accept_s) begin
            taken_d = cond_eval(cc_code, eflags_d);
        end else begin
            taken_d = taken_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eflags_q     <= RST_VAL;
            pending_q    <= PEND_ZERO;
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            eflags_q     <= eflags_d;
            pending_q    <= pending_d;
            resp_valid_q <= resp_valid_d;
            taken_q      <= taken_d;
        end
    end

    assign eflags_out    = eflags_q;
    assign cc_resp_valid = resp_valid_q;
    assign cc_taken      = taken_q;

endmodule

// File: tb/tb_eflags_cond_unit.sv
// Directed bench for eflags_cond_unit: reset, masked writes, condition sweeps,
// hazard stall with bypass, counter saturation and flush.
module tb_eflags_cond_unit;

    logic        clk;
    logic        reset_n;
    logic        fw_issue;
    logic        fw_issue_ready;
    logic        flush;
    logic        wb_valid;
    logic [31:0] wb_flags;
    logic [31:0] wb_mask;
    logic        cc_req_valid;
    logic [3:0]  cc_code;
    logic        cc_req_ready;
    logic        cc_resp_valid;
    logic        cc_taken;
    logic [31:0] eflags_out;

    int n_checks;
    int n_errors;

    eflags_cond_unit #(.MAX_PENDING(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fw_issue      (fw_issue),
        .fw_issue_ready(fw_issue_ready),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_flags      (wb_flags),
        .wb_mask       (wb_mask),
        .cc_req_valid  (cc_req_valid),
        .cc_code       (cc_code),
        .cc_req_ready  (cc_req_ready),
        .cc_resp_valid (cc_resp_valid),
        .cc_taken      (cc_taken),
        .eflags_out    (eflags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [31:0] f, input logic [31:0] m);
        wb_valid = 1'b1;
        wb_flags = f;
        wb_mask  = m;
        tick();
        wb_valid = 1'b0;
        wb_flags = 32'h0000_0000;
        wb_mask  = 32'h0000_0000;
    endtask

    // Issue all 16 codes back-to-back; bit i of exp is the expected result of code i.
    task automatic sweep(input string tag, input logic [15:0] exp);
        cc_req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cc_code = 4'(i);
            tick();
            check_eq({tag, "_valid"}, {31'd0, cc_resp_valid}, 32'd1);
            check_eq($sformatf("%s_code%0h", tag, i), {31'd0, cc_taken}, {31'd0, exp[i]});
        end
        cc_req_valid = 1'b0;
        cc_code      = 4'd0;
        tick();
        check_eq({tag, "_end_valid"}, {31'd0, cc_resp_valid}, 32'd0);
        check_eq({tag, "_hold"}, {31'd0, cc_taken}, {31'd0, exp[15]});
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        fw_issue     = 1'b0;
        flush        = 1'b0;
        wb_valid     = 1'b0;
        wb_flags     = 32'h0000_0000;
        wb_mask      = 32'h0000_0000;
        cc_req_valid = 1'b0;
        cc_code      = 4'd0;

        tick();
        tick();
        check_eq("rst_eflags", eflags_out, 32'h0000_0002);
        check_eq("rst_resp", {31'd0, cc_resp_valid}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset: code 5 (!ZF) on reset flags is true; then reset mid-request.
        cc_req_valid = 1'b1;
        cc_code      = 4'h5;
        tick();
        check_eq("pre_rst_valid", {31'd0, cc_resp_valid}, 32'd1);
        check_eq("pre_rst_taken", {31'd0, cc_taken}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_eflags", eflags_out, 32'h0000_0002);
        check_eq("midrst_valid", {31'd0, cc_resp_valid}, 32'd0);
        check_eq("midrst_taken", {31'd0, cc_taken}, 32'd0);
        tick();
        cc_req_valid = 1'b0;
        reset_n      = 1'b1;
        tick();
        check_eq("postrst_valid", {31'd0, cc_resp_valid}, 32'd0);
        check_eq("postrst_req_rdy", {31'd0, cc_req_ready}, 32'd1);
        check_eq("postrst_iss_rdy", {31'd0, fw_issue_ready}, 32'd1);

        // Masked writes.
        write_flags(32'hFFFF_FFFF, 32'h0000_0041);
        check_eq("mask_41", eflags_out, 32'h0000_0043);
        write_flags(32'h0000_0000, 32'hFFFF_FFFF);
        check_eq("mask_clr", eflags_out, 32'h0000_0002);
        write_flags(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("mask_all", eflags_out, 32'h0000_0CD7);
        write_flags(32'h0000_0000, 32'h0000_0000);
        check_eq("mask_none", eflags_out, 32'h0000_0CD7);

        // ZF=1 SF=1 CF=0 OF=0 PF=0.
        write_flags(32'h0000_00C0, 32'hFFFF_FFFF);
        check_eq("sweep1_flags", eflags_out, 32'h0000_00C2);
        sweep("sw1", 16'h595A);

        // OF=1 CF=1 PF=1 ZF=0 SF=0.
        write_flags(32'h0000_0805, 32'hFFFF_FFFF);
        check_eq("sweep2_flags", eflags_out, 32'h0000_0807);
        sweep("sw2", 16'h5665);

        // Hazard stall then bypass of the writeback that sets ZF.
        fw_issue = 1'b1;
        tick();
        fw_issue     = 1'b0;
        cc_req_valid = 1'b1;
        cc_code      = 4'h4;
        #1;
        check_eq("haz_rdy0", {31'd0, cc_req_ready}, 32'd0);
        tick();
        check_eq("haz_noresp", {31'd0, cc_resp_valid}, 32'd0);
        check_eq("haz_rdy1", {31'd0, cc_req_ready}, 32'd0);
        wb_valid = 1'b1;
        wb_flags = 32'h0000_0040;
        wb_mask  = 32'h0000_0040;
        #1;
        check_eq("haz_bypass_rdy", {31'd0, cc_req_ready}, 32'd1);
        tick();
        wb_valid     = 1'b0;
        wb_mask      = 32'h0000_0000;
        wb_flags     = 32'h0000_0000;
        cc_req_valid = 1'b0;
        check_eq("haz_resp", {31'd0, cc_resp_valid}, 32'd1);
        check_eq("haz_taken", {31'd0, cc_taken}, 32'd1);
        check_eq("haz_eflags", eflags_out, 32'h0000_0847);
        check_eq("haz_clear", {31'd0, cc_req_ready}, 32'd1);

        // Writeback with nothing pending must not underflow.
        write_flags(32'h0000_0000, 32'h0000_0000);
        fw_issue = 1'b1;
        tick();
        fw_issue = 1'b0;
        #1;
        check_eq("no_underflow", {31'd0, cc_req_ready}, 32'd0);
        write_flags(32'h0000_0000, 32'h0000_0000);
        check_eq("drain_one", {31'd0, cc_req_ready}, 32'd1);

        // Fill the counter.
        fw_issue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_eq("full_iss_rdy", {31'd0, fw_issue_ready}, 32'd0);
        check_eq("full_req_rdy", {31'd0, cc_req_ready}, 32'd0);
        tick();
        wb_valid = 1'b1;
        #1;
        check_eq("full_wb_iss_rdy", {31'd0, fw_issue_ready}, 32'd1);
        tick();
        fw_issue = 1'b0;
        wb_valid = 1'b0;
        #1;
        check_eq("full_stays4", {31'd0, fw_issue_ready}, 32'd0);
        write_flags(32'h0000_0000, 32'h0000_0000);
        check_eq("three_iss_rdy", {31'd0, fw_issue_ready}, 32'd1);
        check_eq("three_req_rdy", {31'd0, cc_req_ready}, 32'd0);

        // Flush with pending=3, commit CF=1/ZF=0, ignore a same-cycle issue.
        flush        = 1'b1;
        fw_issue     = 1'b1;
        wb_valid     = 1'b1;
        wb_flags     = 32'h0000_0001;
        wb_mask      = 32'h0000_0041;
        cc_req_valid = 1'b1;
        cc_code      = 4'h2;
        #1;
        check_eq("flush_req_rdy", {31'd0, cc_req_ready}, 32'd0);
        check_eq("flush_iss_rdy", {31'd0, fw_issue_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        fw_issue = 1'b0;
        wb_valid = 1'b0;
        wb_mask  = 32'h0000_0000;
        wb_flags = 32'h0000_0000;
        #1;
        check_eq("flush_noresp", {31'd0, cc_resp_valid}, 32'd0);
        check_eq("flush_eflags", eflags_out, 32'h0000_0807);
        check_eq("postflush_rdy", {31'd0, cc_req_ready}, 32'd1);
        tick();
        cc_req_valid = 1'b0;
        check_eq("postflush_resp", {31'd0, cc_resp_valid}, 32'd1);
        check_eq("postflush_cf", {31'd0, cc_taken}, 32'd1);
        tick();
        check_eq("final_idle", {31'd0, cc_resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eflags_cond_unit.md
Name: eflags_cond_unit

Overview:
- Architectural EFLAGS holder and consumer of the ALU flag word: receives the 32-bit flags output of the ALU at writeback and commits the selected bits.
- Evaluates x86 condition codes (tttn) for Jcc/SETcc/CMOVcc requests on the most recent committed flag value.
- Tracks in-flight flag-writing instructions and stalls condition requests until those flags have been written back (read-after-write hazard).

Parameters:
- MAX_PENDING, 4, maximum in-flight flag writers tracked; counter width = clog2(MAX_PENDING+1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- fw_issue, input, 1, a flag-writing instruction is issued this cycle.
- fw_issue_ready, output, 1, issue accepted (counter not full).
- flush, input, 1, squash all in-flight flag writers.
- wb_valid, input, 1, flag writeback this cycle.
- wb_flags, input, 32, ALU flag word (OF=11, DF=10, SF=7, ZF=6, AF=4, PF=2, CF=0).
- wb_mask, input, 32, per-bit write enable for wb_flags.
- cc_req_valid, input, 1, condition evaluation request.
- cc_code, input, 4, x86 tttn condition code.
- cc_req_ready, output, 1, request accepted this cycle.
- cc_resp_valid, output, 1, one-cycle pulse, result valid.
- cc_taken, output, 1, condition true.
- eflags_out, output, 32, committed EFLAGS.

Behaviour:
- Reset (async, reset_n=0):
  - eflags = 32'h00000002 (bit 1 reads 1, all other bits 0).
  - pending = 0; cc_resp_valid = 0; cc_taken = 0.
  - A request in flight during reset is dropped, and no response is produced afterwards.
- Storage:
  - Only bits 11, 10, 7, 6, 4, 2 and 0 are writable.
  - Bit 1 is constant 1; all other bits are constant 0, regardless of wb_flags or wb_mask.
- Merged flags (combinational):
  - merged = wb_valid ? (eflags & ~wb_mask) | (wb_flags & wb_mask), restricted to the writable bits : eflags.
  - eflags <= merged on every clock.
  - eflags_out shows the registered value.
- Pending counter, next value:
  - flush=1: pending <= 0; fw_issue ignored that cycle; wb_valid still commits its flags.
  - Otherwise: pending <= pending + (fw_issue & fw_issue_ready) − (wb_valid & pending!=0).
  - wb_valid with pending=0 commits the flags; the counter stays 0 (no underflow).
  - fw_issue and wb_valid in the same cycle leave the count unchanged.
- fw_issue_ready = (pending != MAX_PENDING) | wb_valid | flush.
- cc_req_ready = !flush & ((pending==0) | (pending==1 & wb_valid)).
  - The pending==1 case takes the bypass path: the request sees the flags written back that same cycle.
- Accept: cc_req_valid & cc_req_ready.
  - Evaluate cc_code on merged.
  - Register the result: next cycle cc_resp_valid=1 and cc_taken=result; otherwise cc_resp_valid=0.
  - cc_taken holds its last value when cc_resp_valid=0.
- A requester holds cc_req_valid and cc_code stable until ready; the block is stateless with respect to unaccepted requests.
- Back-to-back accepted requests produce back-to-back responses (throughput 1 per cycle, latency 1).
- Condition codes:
  - 0 OF, 1 !OF
  - 2 CF, 3 !CF
  - 4 ZF, 5 !ZF
  - 6 CF|ZF, 7 !(CF|ZF)
  - 8 SF, 9 !SF
  - A PF, B !PF
  - C SF^OF, D !(SF^OF)
  - E ZF|(SF^OF), F !(ZF|(SF^OF))
- No internal FSM beyond the counter and the response register; all outputs except the ready signals are registered.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 mid-request.
  - Required: eflags_out=32'h00000002, cc_resp_valid=0, pending=0; after release, cc_req_ready=1 with no spurious response.
- Masked write:
  - Stimulus: wb_valid, wb_flags=32'hFFFFFFFF, wb_mask=32'h00000041.
  - Required: eflags_out=32'h00000043.
  - Then wb_flags=0, wb_mask=32'hFFFFFFFF.
  - Required: eflags_out=32'h00000002.
- Condition sweep:
  - Stimulus: flags ZF=1, CF=0, SF=1, OF=0; request all 16 codes back-to-back.
  - Required: taken for codes 5→0, 6→1, 7→0, C→1, E→1, F→0.
  - Required: 16 consecutive cc_resp_valid pulses.
- Hazard stall:
  - Stimulus: fw_issue; request code 4 the next cycle.
  - Required: cc_req_ready=0 until writeback.
  - Stimulus: wb_valid with ZF=1 in the same cycle as the held request.
  - Required: request accepted (bypass), next cycle cc_taken=1.
- Counter full:
  - Stimulus: 4 issues with no writeback.
  - Required: fw_issue_ready=0; a 5th issue is not counted.
  - Stimulus: issue and wb_valid in the same cycle.
  - Required: issue accepted, pending stays 4.
- Flush:
  - Stimulus: pending=3; flush with wb_valid CF=1.
  - Required: CF committed; pending=0 next cycle; cc_req_ready=0 during the flush cycle and 1 after.
